// File: rtl/inst_fetch_queue.sv
// ============================================================================
// inst_fetch_queue : fetch PC owner + {pc, inst, next_pc} FIFO to the decoder.
// Optional macro FETCH_JAL_PREDICT_EN enables static JAL target prediction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int          QUEUE_DEPTH_LOG = 4,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic [31:0] rob_pc,
  output logic        inst_valid,
  output logic [31:0] PC,
  input  logic        inst_ready,
  input  logic [31:0] inst_res,
  input  logic        dec_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_pc
);

  localparam int                       c_DEPTH_N = 1 << QUEUE_DEPTH_LOG;
  localparam logic [QUEUE_DEPTH_LOG:0] c_DEPTH   = {1'b1, {QUEUE_DEPTH_LOG{1'b0}}};
  localparam logic [QUEUE_DEPTH_LOG:0] c_CNT_ONE = (QUEUE_DEPTH_LOG+1)'(1);
  localparam logic [QUEUE_DEPTH_LOG-1:0] c_PTR_ONE = QUEUE_DEPTH_LOG'(1);

  logic [31:0]                r_pc;
  logic [QUEUE_DEPTH_LOG-1:0] r_head;
  logic [QUEUE_DEPTH_LOG-1:0] r_tail;
  logic [QUEUE_DEPTH_LOG:0]   r_count;

  logic [31:0] r_mem_inst [0:c_DEPTH_N-1];
  logic [31:0] r_mem_pc   [0:c_DEPTH_N-1];
  logic [31:0] r_mem_npc  [0:c_DEPTH_N-1];

  logic        w_full;
  logic        w_nonempty;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_npc;

  assign w_full     = (r_count == c_DEPTH);
  assign w_nonempty = (r_count != '0);

  // Request is also held low while reset is asserted so the arbiter sees no fetch.
  assign inst_valid = ~w_full & ~rst_in;
  assign PC         = r_pc;

  assign w_push = rdy_in & ~rob_clear & inst_valid & inst_ready;
  assign w_pop  = rdy_in & ~rob_clear & w_nonempty & dec_ready;

`ifdef FETCH_JAL_PREDICT_EN
  logic        w_is_jal;
  logic [31:0] w_jal_off;

  assign w_is_jal  = (inst_res[6:0] == 7'b1101111);
  assign w_jal_off = {{11{inst_res[31]}}, inst_res[31], inst_res[19:12],
                      inst_res[20], inst_res[30:21], 1'b0};
  assign w_npc     = w_is_jal ? (r_pc + w_jal_off) : (r_pc + 32'd4);
`else
  assign w_npc = r_pc + 32'd4;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_pc    <= rob_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_pc   <= w_npc;
          r_tail <= r_tail + c_PTR_ONE;
        end
        if (w_pop) begin
          r_head <= r_head + c_PTR_ONE;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage carries no reset; its content is only observed while the entry is live.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem_inst[r_tail] <= inst_res;
      r_mem_pc[r_tail]   <= r_pc;
      r_mem_npc[r_tail]  <= w_npc;
    end
  end

  assign out_valid   = w_nonempty;
  assign out_inst    = w_nonempty ? r_mem_inst[r_head] : 32'h0;
  assign out_pc      = w_nonempty ? r_mem_pc[r_head]   : 32'h0;
  assign out_pred_pc = w_nonempty ? r_mem_npc[r_head]  : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// tb_inst_fetch_queue : directed stimulus with a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic [31:0] rob_pc;
  logic        inst_valid;
  logic [31:0] PC;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        dec_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pred_pc;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_queue #(.QUEUE_DEPTH_LOG(4), .RESET_PC(32'h0)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .rob_clear   (rob_clear),
    .rob_pc      (rob_pc),
    .inst_valid  (inst_valid),
    .PC          (PC),
    .inst_ready  (inst_ready),
    .inst_res    (inst_res),
    .dec_ready   (dec_ready),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_pred_pc (out_pred_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] inst);
    int off;
`ifdef FETCH_JAL_PREDICT_EN
    if (inst[6:0] == 7'b1101111) begin
      off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096;
      if (inst[31]) off = off - (1 << 20);
      return pc + 32'(off);
    end
`endif
    off = 4;
    return pc + 32'(off);
  endfunction

  // Reference model: a plain queue plus a fetch PC, advanced on each clock edge.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_q.delete();
      m_pc = 32'h0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        m_q.delete();
        m_pc = rob_pc;
      end else begin
        bit do_push;
        bit do_pop;
        entry_t e;
        do_push = (m_q.size() != 16) && inst_ready;
        do_pop  = (m_q.size() != 0) && dec_ready;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          e.pc   = m_pc;
          e.inst = inst_res;
          e.npc  = next_pc(m_pc, inst_res);
          m_q.push_back(e);
          m_pc = e.npc;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("inst_valid", {31'h0, inst_valid}, {31'h0, m_q.size() != 16});
      chk("PC", PC, m_pc);
      chk("out_valid", {31'h0, out_valid}, {31'h0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("out_pc", out_pc, m_q[0].pc);
        chk("out_inst", out_inst, m_q[0].inst);
        chk("out_pred_pc", out_pred_pc, m_q[0].npc);
      end
    end
  end

  logic [24:0] seq = 25'h1;
  bit          auto_inst = 1'b1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (auto_inst) begin
        seq++;
        inst_res = {seq, 7'h13};
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; rob_pc = 32'h0;
    inst_ready = 1'b0; dec_ready = 1'b0; inst_res = {seq, 7'h13};
    @(negedge clk_in);
    chk("rst inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst PC", PC, 32'h0);
    chk("rst out_pc", out_pc, 32'h0);
    #2 rst_in = 1'b0;

    // Fill: 16 pushes of PC 0..60 then stall full
    inst_ready = 1'b1;
    tick(18);
    chk("full inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("full PC", PC, 32'd64);
    chk("full head pc", out_pc, 32'h0);

    dec_ready = 1'b1;
    tick(1);
    dec_ready = 1'b0;
    chk("pop reopen inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("pop head pc", out_pc, 32'd4);
    tick(1);
    chk("refill PC", PC, 32'd68);

    // Redirect then miss
    rob_clear = 1'b1; rob_pc = 32'h100;
    tick(1);
    rob_clear = 1'b0;
    chk("clr out_valid", {31'h0, out_valid}, 32'h0);
    chk("clr PC", PC, 32'h100);
    inst_ready = 1'b0;
    tick(5);
    chk("miss PC", PC, 32'h100);
    chk("miss inst_valid", {31'h0, inst_valid}, 32'h1);
    inst_ready = 1'b1;
    tick(1);
    chk("miss done PC", PC, 32'h104);
    chk("miss done head", out_pc, 32'h100);

    // Redirect during a hit drops that fetch
    rob_clear = 1'b1; rob_pc = 32'h2000;
    tick(1);
    rob_clear = 1'b0;
    chk("clr2 out_valid", {31'h0, out_valid}, 32'h0);
    chk("clr2 PC", PC, 32'h2000);
    tick(2);
    chk("pre-stall PC", PC, 32'h2008);
    dec_ready = 1'b1; rdy_in = 1'b0;
    tick(3);
    chk("stall PC", PC, 32'h2008);
    chk("stall head", out_pc, 32'h2000);
    rdy_in = 1'b1; dec_ready = 1'b0;

    // JAL at 0x40
    rob_clear = 1'b1; rob_pc = 32'h40;
    tick(1);
    rob_clear = 1'b0;
    auto_inst = 1'b0; inst_res = 32'h0100006F;
    tick(1);
    auto_inst = 1'b1;
    chk("jal head pc", out_pc, 32'h40);
`ifdef FETCH_JAL_PREDICT_EN
    chk("jal PC", PC, 32'h50);
    chk("jal pred", out_pred_pc, 32'h50);
`else
    chk("jal PC", PC, 32'h44);
    chk("jal pred", out_pred_pc, 32'h44);
`endif
    inst_res = {seq, 7'h13};

    // Adder wrap
    rob_clear = 1'b1; rob_pc = 32'hFFFF_FFFC;
    tick(1);
    rob_clear = 1'b0;
    tick(1);
    chk("wrap PC", PC, 32'h0);
    chk("wrap head pc", out_pc, 32'hFFFF_FFFC);

    // Mixed traffic exercising pointer wrap, full and empty edges
    for (int k = 0; k < 120; k++) begin
      inst_ready = (k % 3) != 0;
      dec_ready  = (k < 50) ? ((k % 4) == 0) : ((k % 5) < 3);
      rdy_in     = (k % 7) != 6;
      tick(1);
    end
    rdy_in = 1'b1;

    // Reset mid-miss; late inst_ready must not push
    inst_ready = 1'b0; dec_ready = 1'b0;
    tick(2);
    #2 rst_in = 1'b1;
    #1;
    chk("midrst inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("midrst PC", PC, 32'h0);
    chk("midrst out_valid", {31'h0, out_valid}, 32'h0);
    inst_ready = 1'b1;
    tick(1);
    chk("inrst PC", PC, 32'h0);
    #2 rst_in = 1'b0;
    tick(1);
    chk("postrst PC", PC, 32'h4);
    chk("postrst head", out_pc, 32'h0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
